mips_instr_encoder: RTL
=======================

Name: mips_instr_encoder

Overview:
- Streaming assembler: accepts one decoded instruction descriptor per handshake and encodes it into a 32-bit MIPS machine word.
- Writes each word sequentially into instruction memory at BASE_ADDR + 4*index.
- It is the inverse of the CPU's opcode/funct control decoder. It is used to preload IM and as a bench stimulus source, and supports the same 11-instruction subset plus nop.

Parameters:
- DEPTH, 1024, IM capacity in words (power of two, >=2).
- BASE_ADDR, 32'h0000_3000, byte address of the first written word.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a fill session from index 0.
- finish  in  1  pulse; ends the session.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept.
- in_op  in  4  mnemonic code: 0 NOP, 1 ADD, 2 SUB, 3 ADDU, 4 SUBU, 5 ORI, 6 LW, 7 SW, 8 BEQ, 9 LUI, 10 JAL, 11 JR; 12-15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate / offset.
- in_target  in  26  jump index.
- im_we  out  1  IM write strobe.
- im_addr  out  32  IM byte address.
- im_wdata  out  32  encoded word.
- busy  out  1  session active.
- full  out  1  DEPTH words written.
- word_count  out  $clog2(DEPTH)+1  words written this session.
- err  out  1  sticky: an illegal op was seen.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; im_we, im_addr, im_wdata, busy, full, word_count, err all 0; in_ready=0.
- FSM states IDLE, RUN, FULL:
  - IDLE --start--> RUN. On this transition: word_count:=0 and err:=0.
  - RUN --finish--> IDLE.
  - RUN --(accept making word_count==DEPTH)--> FULL.
  - FULL --start--> RUN (clears word_count and err as above). FULL --finish--> IDLE.
  - start while in RUN is ignored.
- in_ready = (state==RUN) && (word_count < DEPTH). It is combinational from registered state only and does not depend on in_valid.
- Accept happens when in_valid && in_ready.
- Latency is 1 cycle. The cycle after a legal accept: im_we=1, im_addr=BASE_ADDR + 4*word_count (pre-increment value), im_wdata=encoded word. word_count increments on the accept edge.
- im_we is a single-cycle pulse per accept. Back-to-back accepts give a continuous im_we stream with consecutive addresses. im_addr and im_wdata hold their last values when im_we=0.
- Illegal op (12-15): the descriptor is consumed (handshake completes), no write, word_count unchanged, err set and held until the next start.
- finish in the same cycle as an accept: the word is still written next cycle, and the state goes to IDLE.
- The accept that makes word_count==DEPTH is written; full=1 from the next cycle.
- Encoding rules (shamt=0; unused fields 0):
  - R-type: op 6'h00; funct ADD 6'h20, ADDU 6'h21, SUB 6'h22, SUBU 6'h23. Word = {op, rs, rt, rd, 5'b0, funct}.
  - JR: {6'h00, rs, 15'b0, 6'h08}.
  - I-type: ORI 6'h0D, LW 6'h23, SW 6'h2B, BEQ 6'h04. Word = {op, rs, rt, imm}.
  - LUI: {6'h0F, 5'b0, rt, imm}.
  - JAL: {6'h03, target}.
  - NOP: 32'h0000_0000.
  - in_imm is copied verbatim; no sign handling.
- Reset asserted mid-session: all state is lost immediately, and any pending im_we is cleared asynchronously.

Decomposition:
- Shared defines header holds:
  - in_op mnemonic codes;
  - opcode constants (OP_SPE, ORI, LW, SW, BEQ, LUI, JAL);
  - funct constants (ADD, SUB, ADDU, SUBU, JR).
- These are the same constants the control decoder uses, so encoder and decoder cannot drift.
- Sub-module mips_encode_comb: purely combinational; maps in_op plus fields to {legal, word}. The top level holds the FSM, counter and output registers.

Test Plan:
- Reset, start, then ORI rs=0 rt=1 imm=16'h1234 -> next cycle im_we=1, im_addr=32'h3000, im_wdata=32'h3401_1234, word_count=1.
- Back-to-back stream ADD(rs1,rt2,rd3), LW(rs5,rt4,imm8), SW(rs5,rt4,imm4), BEQ(rs1,rt2,imm FFFF) -> words 32'h0022_1820, 8CA4_0008, ACA4_0004, 1022_FFFF at 3000/3004/3008/300C with no gaps.
- JAL target=26'h000C00, JR rs=31, LUI rt=1 imm=ABCD -> 32'h0C00_0C00, 03E0_0008, 3C01_ABCD. in_valid held with in_ready=0 in IDLE -> no im_we.
- in_op=13 mid-stream -> descriptor consumed, no im_we, word_count unchanged, err=1 until the next start clears it.
- DEPTH=4: five valid descriptors -> four writes up to 300C, full=1, in_ready=0, fifth descriptor stalls. finish -> IDLE, busy=0.
- reset_n dropped while im_we=1 -> im_we=0 immediately, word_count=0. After release, start -> first write at 32'h3000.

Source files
------------

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg: mnemonic, opcode and funct constants shared with the control decoder.
package mips_instr_encoder_pkg;
  typedef enum logic [3:0] {
    M_NOP  = 4'd0,
    M_ADD  = 4'd1,
    M_SUB  = 4'd2,
    M_ADDU = 4'd3,
    M_SUBU = 4'd4,
    M_ORI  = 4'd5,
    M_LW   = 4'd6,
    M_SW   = 4'd7,
    M_BEQ  = 4'd8,
    M_LUI  = 4'd9,
    M_JAL  = 4'd10,
    M_JR   = 4'd11
  } mnem_t;
  localparam logic [5:0] OP_SPE = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
endpackage

// File: rtl/mips_encode_comb.sv
// mips_encode_comb: maps a mnemonic plus register/immediate fields to a MIPS machine word.
module mips_encode_comb
  import mips_instr_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);
  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (op)
      M_NOP:  word = '0;
      M_ADD:  word = {OP_SPE, rs, rt, rd, 5'b0, FN_ADD};
      M_SUB:  word = {OP_SPE, rs, rt, rd, 5'b0, FN_SUB};
      M_ADDU: word = {OP_SPE, rs, rt, rd, 5'b0, FN_ADDU};
      M_SUBU: word = {OP_SPE, rs, rt, rd, 5'b0, FN_SUBU};
      M_ORI:  word = {OP_ORI, rs, rt, imm};
      M_LW:   word = {OP_LW, rs, rt, imm};
      M_SW:   word = {OP_SW, rs, rt, imm};
      M_BEQ:  word = {OP_BEQ, rs, rt, imm};
      M_LUI:  word = {OP_LUI, 5'b0, rt, imm};
      M_JAL:  word = {OP_JAL, target};
      M_JR:   word = {OP_SPE, rs, 15'b0, FN_JR};
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: streams instruction descriptors into sequential IM writes at BASE_ADDR + 4*index.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic          busy,
  output logic          full,
  output logic [CW-1:0] word_count,
  output logic          err
);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  state_t      state, state_nx;
  logic        legal, accept, write;
  logic [31:0] word;
  mips_encode_comb u_enc (
    .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd),
    .imm(in_imm), .target(in_target), .legal(legal), .word(word)
  );
  assign in_ready = (state == S_RUN) && (word_count < DEPTH_W);
  assign accept   = in_valid && in_ready;
  assign write    = accept && legal;
  assign busy     = state != S_IDLE;
  assign full     = state == S_FULL;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
      S_RUN:   state_nx = finish ? S_IDLE : (write && word_count == DEPTH_W - 1'b1) ? S_FULL : S_RUN;
      default: state_nx = start ? S_RUN : finish ? S_IDLE : S_FULL;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      word_count <= '0;
      err        <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
    end else begin
      state <= state_nx;
      im_we <= write;
      if (start && state != S_RUN) begin
        word_count <= '0;
        err        <= 1'b0;
      end else if (write)
        word_count <= word_count + 1'b1;
      else if (accept)
        err <= 1'b1;
      if (write) begin
        im_addr  <= BASE_ADDR + (32'(word_count) << 2);
        im_wdata <= word;
      end
    end
endmodule
